ram_arbiter: RTL and testbench

//  Shares one 8192x32 byte-writable synchronous RAM between NREQ requesters (CPU, DMA, loader).
//  - One access per clock; round-robin grant among active requesters.
//  - Optional per-requester lock gives atomic read-modify-write sequences.
//  - Drives the RAM's active-low byte selects and rnw; returns read data one cycle after grant.

---
 rtl/ram_pkg.sv | 10 +
 rtl/rr_pick.sv | 35 +++
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants for the 8192x32 byte-writable RAM and its arbiter.
//   RAM_AW / RAM_DW / RAM_NBE : word address width, data width, byte lanes
//   CS_IDLE / RNW_IDLE        : RAM pin values when nothing is granted
package ram_pkg;
  localparam int       RAM_AW   = 13;
  localparam int       RAM_DW   = 32;
  localparam int       RAM_NBE  = RAM_DW / 8;
  localparam logic [3:0] CS_IDLE  = 4'b1111;
  localparam logic       RNW_IDLE = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i  : candidate requests (already lock-masked by the caller)
//   last_i : index granted most recently; the scan starts at last_i+1
//   gnt_o  : one-hot grant
//   idx_o  : encoded grant index (valid when any_o)
//   any_o  : some request was granted
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int c;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    // k runs 1..NREQ so the last granted index is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last_i) + k) % NREQ;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous byte-writable RAM among NREQ
// requesters, with optional per-requester lock for atomic sequences.
//   clk, reset            : clock, asynchronous active-high reset
//   req/rnw/lock          : per-requester request, 1=read, hold-ownership
//   addr/wdata/be         : per-requester packed fields (requester i at i*W)
//   ack                   : one-hot, combinational; transfer taken at this edge
//   rvalid/rdata          : read return, one cycle after ack
//   ram_*                 : RAM pins (cs_b active-low byte selects), ram_dout back
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RAM_AW,
  parameter int DW   = RAM_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      rnw,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  input  logic [NREQ*4-1:0]    be,
  input  logic [NREQ-1:0]      lock,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        ram_address,
  output logic [DW-1:0]        ram_din,
  output logic                 ram_rnw,
  output logic [3:0]           ram_cs_b,
  input  logic [DW-1:0]        ram_dout
);

  localparam int IW = $clog2(NREQ);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rnw;
    logic [3:0]    cs_b;
  } drv_t;

  logic [IW-1:0]   last_q, last_d, owner_q, owner_d, idx;
  logic            owner_vld_q, owner_vld_d, any;
  logic [NREQ-1:0] rvalid_q, req_m, gnt;
  drv_t            drv;

  // Nothing is granted during reset; a live owner masks everyone else.
  always_comb begin
    req_m = reset ? '0 : req;
    if (owner_vld_q) req_m = req_m & (NREQ'(1) << owner_q);
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (req_m),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (idx),
    .any_o  (any)
  );

  assign ack = gnt;

  // Idle leaves requester 0's address/data on the pins with no selects.
  always_comb begin
    drv.addr = addr[0 +: AW];
    drv.din  = wdata[0 +: DW];
    drv.rnw  = RNW_IDLE;
    drv.cs_b = CS_IDLE;
    if (any) begin
      drv.addr = addr[idx*AW +: AW];
      drv.din  = wdata[idx*DW +: DW];
      drv.rnw  = rnw[idx];
      drv.cs_b = rnw[idx] ? 4'b0000 : ~be[idx*4 +: 4];
    end
  end

  assign ram_address = drv.addr;
  assign ram_din     = drv.din;
  assign ram_rnw     = drv.rnw;
  assign ram_cs_b    = drv.cs_b;

  // Ownership drops at the first edge the owner's lock is low, requesting or
  // not; that same cycle's owner access has already been granted above.
  always_comb begin
    last_d      = any ? idx : last_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    if (owner_vld_q) begin
      if (!lock[owner_q]) owner_vld_d = 1'b0;
    end else if (any && lock[idx]) begin
      owner_vld_d = 1'b1;
      owner_d     = idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q      <= IW'(NREQ - 1);
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      rvalid_q    <= '0;
    end else begin
      last_q      <= last_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      rvalid_q    <= ack & rnw;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 13;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req, rnw, lock, ack, rvalid;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [7:0]      be;
  logic [DW-1:0]   rdata, ram_din, ram_dout;
  logic [AW-1:0]   ram_address;
  logic            ram_rnw;
  logic [3:0]      ram_cs_b;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .rnw(rnw), .addr(addr),
    .wdata(wdata), .be(be), .lock(lock), .ack(ack), .rvalid(rvalid),
    .rdata(rdata), .ram_address(ram_address), .ram_din(ram_din),
    .ram_rnw(ram_rnw), .ram_cs_b(ram_cs_b), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural ram_8192x32: synchronous, active-low byte selects.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_cs_b != 4'b1111) begin
      if (!ram_rnw) begin
        for (int b = 0; b < 4; b++)
          if (!ram_cs_b[b]) mem[ram_address][b*8 +: 8] <= ram_din[b*8 +: 8];
      end else begin
        ram_dout <= mem[ram_address];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req, rnw, lock;
    logic [12:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  be0, be1;
    logic [1:0]  eack;
    logic [3:0]  ecs;
    logic        ernw;
    logic [12:0] eaddr;
    logic [1:0]  erv;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [19];
  int   grants0, grants1;

  initial begin
    // read 5; then req1 read so test-2 starts with pointer at last=1
    vecs[0]  = '{2'b01,2'b11,2'b00,13'h5,13'h0,   32'h0,32'h0,4'h0,4'h0, 2'b01,4'b0000,1'b1,13'h5,   2'b00,32'h0};
    vecs[1]  = '{2'b10,2'b11,2'b00,13'h5,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b10,4'b0000,1'b1,13'h1FFF,2'b01,32'hDEADBEEF};
    // both requesting: 0,1,0,1
    vecs[2]  = '{2'b11,2'b11,2'b00,13'h5,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b01,4'b0000,1'b1,13'h5,   2'b10,32'hAABBCCDD};
    vecs[3]  = '{2'b11,2'b11,2'b00,13'h5,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b10,4'b0000,1'b1,13'h1FFF,2'b01,32'hDEADBEEF};
    vecs[4]  = '{2'b11,2'b11,2'b00,13'h5,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b01,4'b0000,1'b1,13'h5,   2'b10,32'hAABBCCDD};
    vecs[5]  = '{2'b11,2'b11,2'b00,13'h5,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b10,4'b0000,1'b1,13'h1FFF,2'b01,32'hDEADBEEF};
    // partial byte write then read-back
    vecs[6]  = '{2'b10,2'b01,2'b00,13'h5,13'h1FFF,32'h0,32'h11223344,4'h0,4'b0101, 2'b10,4'b1010,1'b0,13'h1FFF,2'b10,32'hAABBCCDD};
    vecs[7]  = '{2'b10,2'b11,2'b00,13'h5,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b10,4'b0000,1'b1,13'h1FFF,2'b00,32'h0};
    vecs[8]  = '{2'b00,2'b11,2'b00,13'h10,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b00,4'b1111,1'b1,13'h10,  2'b10,32'hAA22CC44};
    // locked RMW by req0 while req1 keeps requesting
    vecs[9]  = '{2'b11,2'b11,2'b01,13'h10,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b01,4'b0000,1'b1,13'h10,  2'b00,32'h0};
    vecs[10] = '{2'b11,2'b10,2'b00,13'h10,13'h1FFF,32'hCAFEF00D,32'h0,4'hF,4'h0, 2'b01,4'b0000,1'b0,13'h10,2'b01,32'h01020304};
    vecs[11] = '{2'b10,2'b11,2'b00,13'h10,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b10,4'b0000,1'b1,13'h1FFF,2'b00,32'h0};
    // owner drops req with lock high: bus idles until lock falls
    vecs[12] = '{2'b11,2'b11,2'b01,13'h10,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b01,4'b0000,1'b1,13'h10,  2'b10,32'hAA22CC44};
    vecs[13] = '{2'b10,2'b11,2'b01,13'h10,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b00,4'b1111,1'b1,13'h10,  2'b01,32'hCAFEF00D};
    vecs[14] = '{2'b10,2'b11,2'b00,13'h10,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b00,4'b1111,1'b1,13'h10,  2'b00,32'h0};
    vecs[15] = '{2'b10,2'b11,2'b00,13'h10,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b10,4'b0000,1'b1,13'h1FFF,2'b00,32'h0};
    // be=0 write is a no-op
    vecs[16] = '{2'b01,2'b00,2'b00,13'h20,13'h1FFF,32'hFFFFFFFF,32'h0,4'h0,4'h0, 2'b01,4'b1111,1'b0,13'h20,2'b10,32'hAA22CC44};
    vecs[17] = '{2'b01,2'b11,2'b00,13'h20,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b01,4'b0000,1'b1,13'h20,  2'b00,32'h0};
    vecs[18] = '{2'b00,2'b11,2'b00,13'h20,13'h1FFF,32'h0,32'h0,4'h0,4'h0, 2'b00,4'b1111,1'b1,13'h20,  2'b01,32'h55667788};

    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[13'h5]    = 32'hDEADBEEF;
    mem[13'h1FFF] = 32'hAABBCCDD;
    mem[13'h10]   = 32'h01020304;
    mem[13'h20]   = 32'h55667788;
    ram_dout = '0;

    reset = 1'b1; req = '0; rnw = '1; lock = '0; addr = '0; wdata = '0; be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ack",    32'(ack),      32'h0);
    chk("reset_rvalid", 32'(rvalid),   32'h0);
    chk("reset_cs_b",   32'(ram_cs_b), 32'hF);
    chk("reset_rnw",    32'(ram_rnw),  32'h1);
    #1 reset = 1'b0;

    grants0 = 0; grants1 = 0;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      req = vecs[i].req; rnw = vecs[i].rnw; lock = vecs[i].lock;
      addr  = {vecs[i].a1, vecs[i].a0};
      wdata = {vecs[i].d1, vecs[i].d0};
      be    = {vecs[i].be1, vecs[i].be0};
      @(negedge clk);
      chk($sformatf("v%0d_ack", i),    32'(ack),         32'(vecs[i].eack));
      chk($sformatf("v%0d_cs_b", i),   32'(ram_cs_b),    32'(vecs[i].ecs));
      chk($sformatf("v%0d_rnw", i),    32'(ram_rnw),     32'(vecs[i].ernw));
      chk($sformatf("v%0d_addr", i),   32'(ram_address), 32'(vecs[i].eaddr));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid),      32'(vecs[i].erv));
      if (vecs[i].erv != 2'b00)
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].erd);
      if (i >= 2 && i <= 5) begin
        grants0 += int'(ack[0]);
        grants1 += int'(ack[1]);
      end
    end
    chk("rr_grants0", 32'(grants0), 32'd2);
    chk("rr_grants1", 32'(grants1), 32'd2);
    chk("mem_be0_unchanged", mem[13'h20], 32'h55667788);
    chk("mem_rmw_written",   mem[13'h10], 32'hCAFEF00D);

    // Reset in the cycle after a read ack drops the return.
    @(posedge clk); #1;
    req = 2'b01; rnw = 2'b11; lock = '0; addr = {13'h1FFF, 13'h5};
    @(negedge clk);
    chk("rst_pre_ack", 32'(ack), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1; req = 2'b11;
    #1;
    chk("rst_rvalid", 32'(rvalid),   32'h0);
    chk("rst_cs_b",   32'(ram_cs_b), 32'hF);
    chk("rst_ack",    32'(ack),      32'h0);
    chk("rst_rnw",    32'(ram_rnw),  32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_rvalid", 32'(rvalid), 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_ack", 32'(ack), 32'h1);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(rvalid), 32'h1);
    chk("post_rst_rdata",  rdata,       32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
